// File: rtl/axi_lite_regfile_slave_if.sv
// axi_lite_regfile_slave_if: AXI4-Lite bus bundle with master/slave views
interface axi_lite_regfile_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite register file slave; optional write lock via AXI_REGFILE_WR_LOCK_EN
module axi_lite_regfile_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8
) (
  input logic ACLK,
  input logic ARESETn,
  axi_lite_regfile_slave_if.slave bus
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * STRB_W);
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [0:0]        w_state;
  logic [0:0]        r_state;
  logic              aw_done;
  logic              w_done;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic              w_err;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [STRB_W-1:0] ws;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  r_idx;
  assign aw_hs  = bus.awvalid & bus.awready;
  assign w_hs   = bus.wvalid & bus.wready;
  assign ar_hs  = bus.arvalid & bus.arready;
  assign wa     = aw_done ? aw_addr : bus.awaddr;
  assign wd     = w_done ? w_data : bus.wdata;
  assign ws     = w_done ? w_strb : bus.wstrb;
  assign w_idx  = wa[ADDR_LSB +: IDX_W];
  assign r_idx  = bus.araddr[ADDR_LSB +: IDX_W];
  assign commit = (w_state == W_IDLE) & (aw_done | aw_hs) & (w_done | w_hs);
`ifdef AXI_REGFILE_WR_LOCK_EN
  assign w_err  = (wa >= SPAN) | (regs[0][0] & (w_idx != '0));
`else
  assign w_err  = wa >= SPAN;
`endif
  // write channel: collect AW and W in any order, commit once both are held, then wait for B
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state     <= W_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      aw_addr     <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= 2'b00;
    end else if (w_state == W_IDLE) begin
      if (commit) begin
        w_state     <= W_RESP;
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        bus.awready <= 1'b0;
        bus.wready  <= 1'b0;
        bus.bvalid  <= 1'b1;
        bus.bresp   <= w_err ? 2'b10 : 2'b00;
      end else begin
        if (aw_hs) begin
          aw_done <= 1'b1;
          aw_addr <= bus.awaddr;
        end
        if (w_hs) begin
          w_done <= 1'b1;
          w_data <= bus.wdata;
          w_strb <= bus.wstrb;
        end
        bus.awready <= !(aw_done | aw_hs);
        bus.wready  <= !(w_done | w_hs);
      end
    end else if (bus.bready) begin
      w_state     <= W_IDLE;
      bus.bvalid  <= 1'b0;
      bus.awready <= 1'b1;
      bus.wready  <= 1'b1;
    end
  end
  // register file: byte-lane update on the commit edge of an accepted write
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && !w_err) begin
      for (int b = 0; b < STRB_W; b++)
        if (ws[b]) regs[w_idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end
  // read channel: sample the register file on the AR edge, hold R until accepted
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= 2'b00;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        r_state     <= R_DATA;
        bus.arready <= 1'b0;
        bus.rvalid  <= 1'b1;
        bus.rdata   <= (bus.araddr >= SPAN) ? '0 : regs[r_idx];
        bus.rresp   <= (bus.araddr >= SPAN) ? 2'b10 : 2'b00;
      end else begin
        bus.arready <= 1'b1;
      end
    end else if (bus.rready) begin
      r_state     <= R_IDLE;
      bus.rvalid  <= 1'b0;
      bus.arready <= 1'b1;
    end
  end
endmodule
